// File: rtl/fadd_issue.sv
// Two-stage issue/result wrapper around an external combinational FP32 adder.
// Optional macro FADD_ISSUE_FTZ_EN flushes subnormal operands to signed zero before capture.
module fadd_issue (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_tag,
  output logic [31:0] add_x1,
  output logic [31:0] add_x2,
  input  logic [31:0] add_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_y,
  output logic [4:0]  rsp_tag,
  output logic [15:0] rsp_cnt
);

  typedef enum logic [1:0] {
    SEL_SUM  = 2'd0,
    SEL_QNAN = 2'd1,
    SEL_A    = 2'd2,
    SEL_B    = 2'd3
  } sel_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

`ifdef FADD_ISSUE_FTZ_EN
  function automatic logic [31:0] flush(input logic [31:0] x);
    if ((x[30:23] == 8'h00) && (x[22:0] != 23'd0))
      return {x[31], 31'd0};
    else
      return x;
  endfunction
`endif

  logic        s1_valid;
  logic [31:0] s1_a;
  logic [31:0] s1_b;
  logic [4:0]  s1_tag;
  sel_t        s1_sel;

  logic        s2_valid;
  logic [31:0] s2_y;
  logic [4:0]  s2_tag;
  logic [15:0] cnt;

  logic        s1_adv;
  logic        accept;
  logic        rsp_fire;
  logic [31:0] a_in;
  logic [31:0] b_raw;
  logic [31:0] b_in;
  sel_t        sel_in;
  logic [31:0] s1_result;

  assign s1_adv    = s1_valid && (!s2_valid || rsp_ready);
  assign req_ready = !s1_valid || s1_adv;
  assign accept    = req_valid && req_ready;
  assign rsp_fire  = s2_valid && rsp_ready;

  // Operand conditioning: optional flush, then subtraction folded into b's sign.
  always_comb begin
`ifdef FADD_ISSUE_FTZ_EN
    a_in  = flush(req_a);
    b_raw = flush(req_b);
`else
    a_in  = req_a;
    b_raw = req_b;
`endif
    b_in = {b_raw[31] ^ req_op, b_raw[30:0]};
  end

  always_comb begin
    sel_in = SEL_SUM;
    if (is_nan(a_in) || is_nan(b_in) ||
        (is_inf(a_in) && is_inf(b_in) && (a_in[31] != b_in[31])))
      sel_in = SEL_QNAN;
    else if (is_inf(a_in))
      sel_in = SEL_A;
    else if (is_inf(b_in))
      sel_in = SEL_B;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_a     <= 32'd0;
      s1_b     <= 32'd0;
      s1_tag   <= 5'd0;
      s1_sel   <= SEL_SUM;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= a_in;
      s1_b     <= b_in;
      s1_tag   <= req_tag;
      s1_sel   <= sel_in;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  assign add_x1 = s1_a;
  assign add_x2 = s1_b;

  always_comb begin
    s1_result = add_y;
    case (s1_sel)
      SEL_QNAN: s1_result = QNAN;
      SEL_A:    s1_result = s1_a;
      SEL_B:    s1_result = s1_b;
      default:  s1_result = add_y;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_y     <= 32'd0;
      s2_tag   <= 5'd0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_y     <= s1_result;
      s2_tag   <= s1_tag;
    end else if (rsp_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt <= 16'd0;
    else if (rsp_fire)
      cnt <= cnt + 16'd1;
  end

  assign rsp_valid = s2_valid;
  assign rsp_y     = s2_y;
  assign rsp_tag   = s2_tag;
  assign rsp_cnt   = cnt;

endmodule
